// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Used by the fetch unit and its instruction buffer.
package fetch_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    localparam int OP_LSB     = 0;
    localparam int OP_MSB     = 6;
    localparam int OP5_B      = 5;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_MSB = 14;
    localparam int FUNCT7_B5  = 30;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetched {instr, pc} entries.
// Flush wins over any same-cycle push or pop.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic [AW:0]  count
);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_pop;

    assign do_pop = pop && (count != '0);
    assign rdata  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Power-of-two depth lets the pointers wrap naturally.
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues single-outstanding imem requests,
// buffers responses and presents the head with pre-sliced fields.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter int          BUF_DEPTH = 2,
    parameter int          XLEN      = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic            op5,
    output logic            funct7,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget
);

    localparam int CW = $clog2(BUF_DEPTH);
    localparam logic [CW:0] FULL = (CW+1)'(BUF_DEPTH);

    fetch_state_t    state;
    fetch_state_t    state_nx;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic [CW:0]     count;
    logic            push;
    logic            pop;
    logic            hs;
    fetch_entry_t    head;
    fetch_entry_t    wdata;

    assign hs        = imem_req_valid && imem_req_ready;
    assign imem_addr = fetch_pc;

    always_comb begin
        state_nx       = state;
        imem_req_valid = 1'b0;
        push           = 1'b0;
        unique case (state)
            REQ: begin
                // Only issue when a buffer slot is guaranteed for the reply.
                imem_req_valid = rst_n && (count < FULL) && !PCSrc;
                if (imem_req_valid && imem_req_ready)
                    state_nx = WAIT;
            end
            WAIT: begin
                if (PCSrc)
                    state_nx = imem_rsp_valid ? REQ : DROP;
                else if (imem_rsp_valid) begin
                    push     = 1'b1;
                    state_nx = REQ;
                end
            end
            DROP: begin
                if (imem_rsp_valid)
                    state_nx = REQ;
            end
            default: state_nx = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= REQ;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else begin
            state <= state_nx;
            if (PCSrc)
                fetch_pc <= {PCTarget[XLEN-1:2], 2'b00};
            else if (hs)
                fetch_pc <= fetch_pc + 32'd4;
            if (hs)
                req_pc <= fetch_pc;
        end
    end

    assign wdata = '{instr: imem_rsp_data, pc: req_pc};
    assign pop   = instr_valid && instr_ready;

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (PCSrc),
        .wdata (wdata),
        .rdata (head),
        .count (count)
    );

    assign instr_valid = rst_n && (count != '0);
    assign instr       = instr_valid ? head.instr : NOP_INSTR;
    assign instr_pc    = instr_valid ? head.pc : '0;
    assign op          = instr[OP_MSB:OP_LSB];
    assign funct3      = instr[FUNCT3_MSB:FUNCT3_LSB];
    assign op5         = instr[OP5_B];
    assign funct7      = instr[FUNCT7_B5];

endmodule
